// File: rtl/sobel_pkg.sv
// Shared Sobel types and constants: window layout, kernel coefficients, saturation.
package sobel_pkg;
  localparam int SOBEL_PIX_W = 8;
  localparam int MAG_W       = SOBEL_PIX_W + 4;

  // Coefficients indexed [row][col], row 0 = top, col 0 = left
  localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  typedef logic [2:0][2:0][SOBEL_PIX_W-1:0] win_t;

  function automatic logic [SOBEL_PIX_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (m > MAG_W'((1 << SOBEL_PIX_W) - 1)) ? '1 : m[SOBEL_PIX_W-1:0];
  endfunction
endpackage

// File: rtl/sobel_kernel_3x3.sv
// Combinational 3x3 Sobel: Gx/Gy, |Gx|+|Gy|, saturated to pixel width.
module sobel_kernel_3x3
  import sobel_pkg::*;
(
  input  win_t                   win,
  output logic [SOBEL_PIX_W-1:0] mag
);
  logic signed [MAG_W-1:0] gx, gy;
  logic        [MAG_W-1:0] ax, ay, sum;

  always_comb begin
    gx = '0;
    gy = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx = gx + MAG_W'(KX[r][c]) * $signed(MAG_W'(win[r][c]));
        gy = gy + MAG_W'(KY[r][c]) * $signed(MAG_W'(win[r][c]));
      end
    end
    ax  = gx[MAG_W-1] ? MAG_W'(-gx) : MAG_W'(gx);
    ay  = gy[MAG_W-1] ? MAG_W'(-gy) : MAG_W'(gy);
    sum = ax + ay;
    mag = sat_mag(sum);
  end
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel with internal line buffers; two-stage pipeline.
// Define SOBEL_THRESH_EN to add the thresh port and emit a binary edge map.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = SOBEL_PIX_W,
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_eol,
  output logic             out_eof
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [PIX_W-1:0] thresh
`endif
);
  localparam int STAGES = 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic              stall, acc, win_done, s1_eol, s1_eof;
  logic [CW-1:0]     col, cur_col;
  logic [RW-1:0]     row, cur_row;
  logic [STAGES:1]   vld_pipe;
  logic [PIX_W-1:0]  lb0 [IMG_W];
  logic [PIX_W-1:0]  lb1 [IMG_W];
  logic [PIX_W-1:0]  lb0_rd, lb1_rd, mag, res;
  win_t              win;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !rst && !stall;
  assign acc       = in_valid && in_ready;
  // An SOF pixel is (0,0) regardless of where the counters had got to
  assign cur_col   = in_sof ? '0 : col;
  assign cur_row   = in_sof ? '0 : row;
  assign win_done  = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign lb0_rd    = lb0[cur_col];
  assign lb1_rd    = lb1[cur_col];
  assign out_valid = vld_pipe[STAGES];

  // lb0 holds row-1, lb1 holds row-2; window column 2 is the newest
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[cur_col] <= in_pix;
      lb1[cur_col] <= lb0_rd;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= in_pix;
    end
  end

  sobel_kernel_3x3 u_kernel (.win(win), .mag(mag));

`ifdef SOBEL_THRESH_EN
  assign res = (mag >= thresh) ? '1 : '0;
`else
  assign res = mag;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      vld_pipe <= '0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      out_pix  <= '0;
      out_eol  <= 1'b0;
      out_eof  <= 1'b0;
    end else begin
      if (acc) begin
        if (cur_col == CW'(IMG_W-1)) begin
          col <= '0;
          row <= (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
      if (!stall) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], win_done};
        s1_eol   <= cur_col == CW'(IMG_W-1);
        s1_eof   <= (cur_col == CW'(IMG_W-1)) && (cur_row == RW'(IMG_H-1));
        if (vld_pipe[1]) begin
          out_pix <= res;
          out_eol <= s1_eol;
          out_eof <= s1_eof;
        end
      end
    end
  end
endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming 3x3 Sobel edge detector for raster video. It accepts one pixel per cycle over a valid/ready handshake and buffers two image lines internally to build the 3x3 window itself, so upstream no longer presents a pre-assembled 72-bit window. It emits one saturated gradient magnitude per interior pixel. It sits between the frame memory reader and the display/output memory writer.

## Interface
- PIX_W, 8, pixel and output magnitude width in bits
- IMG_W, 100, pixels per line (>= 3)
- IMG_H, 100, lines per frame (>= 3)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept the input pixel this cycle
- in_pix  in  PIX_W  input pixel, raster order
- in_sof  in  1  marks the first pixel (0,0) of a frame; qualified by in_valid && in_ready
- out_valid  out  1  output magnitude valid
- out_ready  in  1  downstream accepts the output
- out_pix  out  PIX_W  gradient magnitude, or binary edge when thresholding is enabled
- out_eol  out  1  last output of an output line
- out_eof  out  1  last output of a frame
- thresh  in  PIX_W  edge threshold; present only with SOBEL_THRESH_EN

## Operation
- Accept occurs when in_valid && in_ready. Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) track the position of the accepted pixel.
- On accept with in_sof=1, the pixel is treated as (0,0). Counters reload and the window-valid state clears, so any partial frame is discarded.
- After (IMG_H-1, IMG_W-1) is accepted, both counters wrap to 0 without in_sof.
- Two line buffers, each IMG_W x PIX_W, are organised as inferred RAM with one read and one write per accept. Three 3-column window shift registers are fed from line buffer 0, line buffer 1 and in_pix.
- A pixel accepted at (row,col) with row>=2 and col>=2 completes the window centred at (row-1, col-1). Only these windows produce an output, giving (IMG_W-2)*(IMG_H-2) outputs per frame. Border pixels produce no output.
- Gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20); Gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02). Both are signed, PIX_W+4 bits.
- mag = |Gx| + |Gy|, unsigned PIX_W+4 bits. It saturates to 2^PIX_W-1 when it exceeds that value.
- out_eol is set when the centre column is IMG_W-2. out_eof is set when the centre is (IMG_H-2, IMG_W-2).

## Timing
- Pipeline stages: S1 = accept and window shift; S2 = kernel arithmetic registered into out_pix/out_valid.
- stall = out_valid && !out_ready. When stall is high, S1 and S2 both hold and no accept occurs.
- in_ready = !rst && !stall. This path is combinational from out_ready.
- Latency: an accept at edge N that completes a window gives out_valid=1 after edge N+1. Sustained throughput is 1 pixel/cycle when out_ready=1.
- out_pix, out_eol and out_eof are held stable while out_valid && !out_ready.
- When out_valid=1, out_ready=1 and a new window is completing, the output updates back-to-back with no bubble.
- An accept with in_sof=1 while an output is pending does not drop that output. The output completes under the normal handshake.
- Reset values: out_valid=0, out_pix=0, out_eol=0, out_eof=0, col=row=0, window-valid=0, in_ready=0 while rst is high. Line buffer contents are not cleared.
- rst mid-frame: out_valid is 0 after the reset edge, any pending output is lost, and the next accepted pixel is (0,0).

## Configuration
- SOBEL_THRESH_EN defined: the thresh port exists. out_pix = all-ones when saturated mag >= thresh, otherwise 0.
- SOBEL_THRESH_EN undefined: no thresh port. out_pix = saturated mag.
- Latency is identical in both builds.

## Structure
- Shared package sobel_pkg holds:
  - MAG_W = PIX_W+4;
  - the kernel coefficient constants;
  - the saturation-limit function;
  - the typedef for a 3x3 window of PIX_W pixels.
- One sub-module, sobel_kernel_3x3: combinational Gx/Gy, absolute values, sum and saturation. Inputs are the window; the output is a PIX_W magnitude.
- Line buffers and counters stay in sobel_stream.

## Test plan
Benches use IMG_W=8, IMG_H=6 and PIX_W=8 unless noted.
- Flat frame, all pixels 0x55, in_sof on the first pixel, out_ready=1 -> 24 outputs, all 0x00; out_eol on every 6th output; out_eof on the 24th; first out_valid one cycle after accepting (2,2).
- Vertical edge, columns 0-3 = 0x00 and 4-7 = 0x10 -> out_pix = 0x40 at centre columns 3 and 4, 0x00 elsewhere; 4 rows of output.
- Saturation, columns 0-3 = 0x00 and 4-7 = 0xFF -> out_pix = 0xFF at centre columns 3 and 4, 0x00 elsewhere.
- Backpressure: repeat the vertical-edge case with out_ready toggling 1,0,1,0 and in_valid random -> identical output sequence; in_ready=0 exactly when out_valid && !out_ready; outputs stable while stalled.
- Resync and reset:
  - in_sof asserted at the 20th pixel -> no out_valid until (2,2) of the new frame;
  - rst pulsed mid-frame -> out_valid=0 and in_ready=0 during reset; the next frame outputs correctly.
- SOBEL_THRESH_EN, thresh=0x30, vertical-edge image (0x10) -> 0xFF at centre columns 3 and 4, 0x00 elsewhere; thresh=0x41 -> all 0x00.
